// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bundle: redirect input, instruction-memory request/response, decode handoff.
interface instr_fetch_unit_if;
  localparam int unsigned XLEN = 32;

  logic            redirect;
  logic [XLEN-1:0] redirect_target;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;

  // Fetch unit side
  modport master (
    input  redirect, redirect_target, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc
  );

  // Memory/decode environment side
  modport slave (
    output redirect, redirect_target, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
    input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: sequential PC, 2-deep in-flight address queue,
// 2-deep {instr, pc} FIFO to decode, redirect with stale-response dropping.
module instr_fetch_unit (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_unit_if.master bus
);
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned SUM_W = 3;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  aq_addr_q [DEPTH];
  logic [XLEN-1:0]  aq_addr_d [DEPTH];
  logic             aq_rd_q, aq_rd_d, aq_wr_q, aq_wr_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [XLEN-1:0]  fifo_instr_q [DEPTH];
  logic [XLEN-1:0]  fifo_instr_d [DEPTH];
  logic [XLEN-1:0]  fifo_pc_q [DEPTH];
  logic [XLEN-1:0]  fifo_pc_d [DEPTH];
  logic             fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;

  logic credit_c, req_fire_c, rsp_take_c, fifo_push_c, fifo_pop_c;

  // Output drive and handshake strobes; the credit counts dropped requests too
  always_comb begin
    credit_c            = (SUM_W'(inflight_q) + SUM_W'(fifo_cnt_q)) < SUM_W'(DEPTH);
    bus.imem_req_valid  = !reset && !bus.redirect && credit_c;
    bus.imem_req_addr   = pc_q;
    bus.id_valid        = !reset && (fifo_cnt_q != '0);
    bus.id_instr        = reset ? '0 : fifo_instr_q[fifo_rd_q];
    bus.id_pc           = reset ? '0 : fifo_pc_q[fifo_rd_q];
    req_fire_c          = bus.imem_req_valid && bus.imem_req_ready;
    rsp_take_c          = bus.imem_rsp_valid && (inflight_q != '0);
    fifo_push_c         = rsp_take_c && (drop_q == '0) && !bus.redirect;
    fifo_pop_c          = bus.id_valid && bus.id_ready;
  end

  // Next-state: request issue, response routing, decode pop, redirect flush
  always_comb begin
    pc_d         = pc_q;
    aq_addr_d    = aq_addr_q;
    aq_rd_d      = aq_rd_q;
    aq_wr_d      = aq_wr_q;
    drop_d       = drop_q;
    fifo_instr_d = fifo_instr_q;
    fifo_pc_d    = fifo_pc_q;
    fifo_rd_d    = fifo_rd_q;
    fifo_wr_d    = fifo_wr_q;

    if (req_fire_c) begin
      aq_addr_d[aq_wr_q] = pc_q;
      aq_wr_d            = !aq_wr_q;
      pc_d               = pc_q + XLEN'(4);
    end
    if (rsp_take_c) begin
      aq_rd_d = !aq_rd_q;
      if (drop_q != '0) drop_d = drop_q - CNT_W'(1);
    end
    inflight_d = inflight_q + CNT_W'(req_fire_c) - CNT_W'(rsp_take_c);

    if (fifo_push_c) begin
      fifo_instr_d[fifo_wr_q] = bus.imem_rsp_data;
      fifo_pc_d[fifo_wr_q]    = aq_addr_q[aq_rd_q];
      fifo_wr_d               = !fifo_wr_q;
    end
    if (fifo_pop_c) fifo_rd_d = !fifo_rd_q;
    fifo_cnt_d = fifo_cnt_q + CNT_W'(fifo_push_c) - CNT_W'(fifo_pop_c);

    // A response in the redirect cycle is already stale, so it leaves the drop count
    if (bus.redirect) begin
      pc_d       = bus.redirect_target & ~XLEN'(3);
      fifo_cnt_d = '0;
      fifo_rd_d  = 1'b0;
      fifo_wr_d  = 1'b0;
      drop_d     = inflight_q - CNT_W'(rsp_take_c);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= '0;
      aq_addr_q    <= '{default: '0};
      aq_rd_q      <= 1'b0;
      aq_wr_q      <= 1'b0;
      inflight_q   <= '0;
      drop_q       <= '0;
      fifo_instr_q <= '{default: '0};
      fifo_pc_q    <= '{default: '0};
      fifo_rd_q    <= 1'b0;
      fifo_wr_q    <= 1'b0;
      fifo_cnt_q   <= '0;
    end else begin
      pc_q         <= pc_d;
      aq_addr_q    <= aq_addr_d;
      aq_rd_q      <= aq_rd_d;
      aq_wr_q      <= aq_wr_d;
      inflight_q   <= inflight_d;
      drop_q       <= drop_d;
      fifo_instr_q <= fifo_instr_d;
      fifo_pc_q    <= fifo_pc_d;
      fifo_rd_q    <= fifo_rd_d;
      fifo_wr_q    <= fifo_wr_d;
      fifo_cnt_q   <= fifo_cnt_d;
    end
  end
endmodule
